// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared types and constants for the common data bus arbiter.
//   NUM_RS        : number of reservation stations / FU result ports (default FU count)
//   ROB_TAG       : reorder-buffer tag; ZERO_REG (tag 0) means "no destination"
//   RS_TAG        : FU / RS index, 0 reserved for "none"
//   CDB_PACKET    : broadcast {rob_tag, v} seen by RS, ROB and map table
//   CDB_BUF_ENTRY : one buffered FU result {rob_tag, value}
package cdb_arbiter_pkg;

    localparam int unsigned NUM_RS    = 6;
    localparam int unsigned ROB_TAG_W = 5;
    // Wide enough for indices 0..NUM_RS; widen together with NUM_RS.
    localparam int unsigned RS_TAG_W  = 3;

    typedef logic [ROB_TAG_W-1:0] ROB_TAG;
    typedef logic [RS_TAG_W-1:0]  RS_TAG;

    localparam ROB_TAG ZERO_REG = '0;

    typedef struct packed {
        ROB_TAG      rob_tag;
        logic [31:0] v;
    } CDB_PACKET;

    typedef struct packed {
        ROB_TAG      rob_tag;
        logic [31:0] value;
    } CDB_BUF_ENTRY;

    localparam CDB_PACKET CDB_IDLE = '{rob_tag: ZERO_REG, v: 32'h0};

    function automatic CDB_PACKET to_packet(input CDB_BUF_ENTRY e);
        CDB_PACKET p;
        p.rob_tag = e.rob_tag;
        p.v       = e.value;
        return p;
    endfunction

endpackage

// File: rtl/cdb_fu_fifo.sv
// cdb_fu_fifo: per-FU result FIFO feeding the CDB arbiter.
// Ports:
//   clk_i   : clock
//   rst_ni  : synchronous active-low reset
//   flush_i : drop all entries (squash); wins over push/pop
//   push_i  : write data_i (caller guarantees !full_o)
//   pop_i   : retire head_o (caller guarantees !empty_o)
//   data_i  : entry to write
//   full_o  : count == BUF_DEPTH
//   empty_o : count == 0
//   head_o  : oldest entry
// BUF_DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module cdb_fu_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  CDB_BUF_ENTRY data_i,
    output logic         full_o,
    output logic         empty_o,
    output CDB_BUF_ENTRY head_o
);

    localparam int unsigned PtrW = $clog2(BUF_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    CDB_BUF_ENTRY    mem_q [BUF_DEPTH];

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            // Simultaneous push and pop leave the count unchanged.
            count_q <= count_q + CntW'(push_i) - CntW'(pop_i);
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign full_o  = (count_q == CntW'(BUF_DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers FU results and broadcasts one per cycle on the CDB.
// Ports:
//   clock      : sole clock
//   reset      : synchronous active-low reset
//   squash     : flush every buffered result; same-cycle fu_done discarded
//   fu_done    : [NUM_FU:1] FU i presents a result
//   fu_rob_tag : per-FU destination ROB tag
//   fu_value   : per-FU result value
//   fu_ready   : [NUM_FU:1] FU i FIFO not full (registered count only)
//   cdb_packet : registered broadcast {rob_tag, v}; {ZERO_REG, 0} when idle
//   cdb_fu_id  : FU index of the broadcast; 0 when idle
// Configuration macro: CDB_ROUND_ROBIN_EN selects round-robin arbitration;
// when undefined the lowest-index non-empty FIFO wins.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_FU    = NUM_RS,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              squash,
    input  logic [NUM_FU:1]   fu_done,
    input  ROB_TAG            fu_rob_tag [NUM_FU:1],
    input  logic [31:0]       fu_value   [NUM_FU:1],
    output logic [NUM_FU:1]   fu_ready,
    output CDB_PACKET         cdb_packet,
    output RS_TAG             cdb_fu_id
);

    logic [NUM_FU:1] push, pop, full, empty;
    CDB_BUF_ENTRY    din  [NUM_FU:1];
    CDB_BUF_ENTRY    head [NUM_FU:1];

    logic      gnt_valid;
    RS_TAG     gnt_idx;
    CDB_PACKET cdb_packet_q;
    RS_TAG     cdb_fu_id_q;

    for (genvar i = 1; i <= NUM_FU; i++) begin : g_fu
        assign fu_ready[i] = ~full[i];
        // Zero-tag results have no consumer and are never buffered.
        assign push[i]     = fu_done[i] & ~full[i] & (fu_rob_tag[i] != ZERO_REG) & ~squash;
        assign din[i]      = '{rob_tag: fu_rob_tag[i], value: fu_value[i]};

        cdb_fu_fifo #(
            .BUF_DEPTH (BUF_DEPTH)
        ) u_fifo (
            .clk_i   (clock),
            .rst_ni  (reset),
            .flush_i (squash),
            .push_i  (push[i]),
            .pop_i   (pop[i]),
            .data_i  (din[i]),
            .full_o  (full[i]),
            .empty_o (empty[i]),
            .head_o  (head[i])
        );

        // A done offered while the FIFO is full is lost; flag it.
        always_ff @(posedge clock) begin
            if (reset && !squash && fu_done[i]) begin
                assert (!full[i])
                    else $warning("cdb_arbiter: FU %0d result dropped, FIFO full", i);
            end
        end
    end

`ifdef CDB_ROUND_ROBIN_EN
    RS_TAG rr_ptr_q, rr_ptr_d;
    RS_TAG cand;

    // Scan upward from rr_ptr with wrap back to 1.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned off = 0; off < NUM_FU; off++) begin
            cand = RS_TAG'(((32'(rr_ptr_q) - 32'd1 + off) % NUM_FU) + 32'd1);
            if (!gnt_valid && !empty[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_valid && !squash) begin
            rr_ptr_d = (gnt_idx == RS_TAG'(NUM_FU)) ? RS_TAG'(1) : gnt_idx + RS_TAG'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) rr_ptr_q <= RS_TAG'(1);
        else        rr_ptr_q <= rr_ptr_d;
    end
`else
    // Fixed priority: first non-empty FIFO from index 1 upward.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int i = 1; i <= NUM_FU; i++) begin
            if (!gnt_valid && !empty[RS_TAG'(i)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = RS_TAG'(i);
            end
        end
    end
`endif

    always_comb begin
        pop = '0;
        if (gnt_valid && !squash) pop[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset || squash || !gnt_valid) begin
            cdb_packet_q <= CDB_IDLE;
            cdb_fu_id_q  <= '0;
        end else begin
            cdb_packet_q <= to_packet(head[gnt_idx]);
            cdb_fu_id_q  <= gnt_idx;
        end
    end

    assign cdb_packet = cdb_packet_q;
    assign cdb_fu_id  = cdb_fu_id_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed self-checking bench for cdb_arbiter (default parameters).
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int unsigned NFU = 6;
`ifdef CDB_ROUND_ROBIN_EN
    localparam logic [2:0] HogE3Id = 3'd4;
`else
    localparam logic [2:0] HogE3Id = 3'd1;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          squash;
    logic [NFU:1]  fu_done;
    ROB_TAG        fu_rob_tag [NFU:1];
    logic [31:0]   fu_value   [NFU:1];
    logic [NFU:1]  fu_ready;
    CDB_PACKET     cdb_packet;
    RS_TAG         cdb_fu_id;

    int checks = 0;
    int errors = 0;
    ROB_TAG q1[$];
    ROB_TAG q4[$];

    always #5 clock = ~clock;

    cdb_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .squash     (squash),
        .fu_done    (fu_done),
        .fu_rob_tag (fu_rob_tag),
        .fu_value   (fu_value),
        .fu_ready   (fu_ready),
        .cdb_packet (cdb_packet),
        .cdb_fu_id  (cdb_fu_id)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        fu_done = '0;
        squash  = 1'b0;
        for (int i = 1; i <= NFU; i++) begin
            fu_rob_tag[i] = '0;
            fu_value[i]   = '0;
        end
    endtask

    task automatic drive(input RS_TAG fu, input ROB_TAG tag);
        fu_done[fu]    = 1'b1;
        fu_rob_tag[fu] = tag;
        fu_value[fu]   = 32'hA000 + 32'(tag);
    endtask

    function automatic logic [39:0] exp_pkt(input RS_TAG id, input ROB_TAG tag);
        return {id, tag, 32'hA000 + 32'(tag)};
    endfunction

    task automatic chk(input string name, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                errors++;
                $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
            end
    endtask

    task automatic chk_pkt(input string name, input logic [39:0] exp);
        chk(name, {cdb_fu_id, cdb_packet}, exp);
    endtask

    task automatic chk_ready(input string name, input logic [NFU:1] exp);
        chk(name, 40'(fu_ready), 40'(exp));
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic record();
        if (cdb_fu_id == 3'd1) q1.push_back(cdb_packet.rob_tag);
        if (cdb_fu_id == 3'd4) q4.push_back(cdb_packet.rob_tag);
    endtask

    initial begin
        clear_inputs();
        reset = 1'b0;
        tick();
        tick();
        chk_pkt("reset_pkt", 40'h0);
        chk_ready("reset_ready", 6'h3F);
        reset = 1'b1;

        // Single result: FU2 tag 5 value 0xDEAD.
        fu_done[2] = 1'b1; fu_rob_tag[2] = 5'd5; fu_value[2] = 32'hDEAD;
        tick();
        clear_inputs();
        chk_pkt("single_edgeN", 40'h0);
        tick();
        chk("single_edgeN1", {cdb_fu_id, cdb_packet}, {3'd2, 5'd5, 32'hDEAD});
        tick();
        chk_pkt("single_idle", 40'h0);

        // Zero-tag result is never broadcast.
        drive(3'd3, 5'd0);
        tick();
        clear_inputs();
        tick();
        chk_pkt("zero_tag_a", 40'h0);
        tick();
        chk_pkt("zero_tag_b", 40'h0);

        // Contention: FU1, FU3, FU5 on the same edge.
        do_reset();
        drive(3'd1, 5'd1); drive(3'd3, 5'd3); drive(3'd5, 5'd5);
        tick();
        clear_inputs();
        chk_pkt("cont_e1", 40'h0);
        tick(); chk_pkt("cont_fu1", exp_pkt(3'd1, 5'd1));
        tick(); chk_pkt("cont_fu3", exp_pkt(3'd3, 5'd3));
        tick(); chk_pkt("cont_fu5", exp_pkt(3'd5, 5'd5));
        tick(); chk_pkt("cont_idle", 40'h0);

        // Full FIFO: FU4 offers 3 results while FU1 is busy every cycle.
        do_reset();
        drive(3'd1, 5'd7); drive(3'd4, 5'd10);
        tick();
        chk_ready("hog_ready_e1", 6'h3F);
        drive(3'd1, 5'd8); drive(3'd4, 5'd11);
        tick();
        chk_ready("hog_ready_e2", 6'h37);
        record();
        drive(3'd1, 5'd9); drive(3'd4, 5'd12);
        tick();
        chk("hog_e3_id", 40'(cdb_fu_id), 40'(HogE3Id));
        record();
        clear_inputs();
        for (int k = 0; k < 8; k++) begin
            tick();
            record();
        end
        chk("hog_fu4_count", 40'(q4.size()), 40'd2);
        chk("hog_fu4_first", 40'(q4.size() > 0 ? q4[0] : 5'h1F), 40'd10);
        chk("hog_fu4_second", 40'(q4.size() > 1 ? q4[1] : 5'h1F), 40'd11);
        chk("hog_fu1_count", 40'(q1.size()), 40'd3);
        chk_ready("hog_ready_end", 6'h3F);

        // Squash with three results buffered and FU6 done alongside.
        do_reset();
        drive(3'd1, 5'd1); drive(3'd2, 5'd2); drive(3'd3, 5'd3);
        tick();
        clear_inputs();
        squash = 1'b1;
        drive(3'd6, 5'd6);
        tick();
        clear_inputs();
        chk_pkt("squash_pkt", 40'h0);
        chk_ready("squash_ready", 6'h3F);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_pkt($sformatf("squash_after_%0d", k), 40'h0);
        end

        // Reset mid-stream with two results queued.
        do_reset();
        drive(3'd1, 5'd13); drive(3'd2, 5'd14);
        tick();
        clear_inputs();
        reset = 1'b0;
        tick();
        chk_pkt("rst_mid_pkt", 40'h0);
        chk_ready("rst_mid_ready", 6'h3F);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_pkt($sformatf("rst_mid_after_%0d", k), 40'h0);
        end

        // Same-cycle push/pop on FU2 with one entry resident.
        do_reset();
        drive(3'd2, 5'd20);
        tick();
        chk_pkt("pp_e1", 40'h0);
        for (int k = 1; k <= 4; k++) begin
            drive(3'd2, ROB_TAG'(20 + k));
            tick();
            chk_pkt($sformatf("pp_pkt_%0d", k), exp_pkt(3'd2, ROB_TAG'(19 + k)));
            chk_ready($sformatf("pp_ready_%0d", k), 6'h3F);
        end
        clear_inputs();
        tick();
        chk_pkt("pp_last", exp_pkt(3'd2, 5'd24));
        tick();
        chk_pkt("pp_idle", 40'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
